// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, single-cycle ops plus iterative shift-add multiply.
// Define ALU_MUL_EARLY_EXIT_EN to end a multiply once no multiplier bits remain.
module alu_seq #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zWrEn,
   output logic             done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_PASS = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_DEC  = 3'd5;
   localparam logic [2:0] OP_AND  = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] mplier_nxt;
   logic [WIDTH-1:0] alu_res;
   logic [CW-1:0]    cnt;
   logic             mul_last;
   logic             do_alu;
   logic             do_nop;
   logic             do_mul;
   logic             mul_fin;

   assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
   assign mplier_nxt = mplier >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
   assign mul_last = (cnt == LAST) || (mplier_nxt == '0);
`else
   assign mul_last = (cnt == LAST);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (do_mul)   state_nxt = MUL;
         MUL:  if (mul_last) state_nxt = IDLE;
      endcase
   end

   always_comb begin
      do_alu  = 1'b0;
      do_nop  = 1'b0;
      do_mul  = 1'b0;
      mul_fin = (state == MUL) && mul_last;
      if (state == IDLE && start) begin
         unique case (1'b1)
            (op == OP_MUL): do_mul = 1'b1;
            (op == OP_NOP): do_nop = 1'b1;
            default:        do_alu = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (op)
         OP_PASS: alu_res = a;
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_INC:  alu_res = a + WIDTH'(1);
         OP_DEC:  alu_res = a - WIDTH'(1);
         OP_AND:  alu_res = a & b;
         default: alu_res = a;
      endcase
   end

   // Multiply operands are captured on the start edge; inputs are ignored after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
         zWrEn  <= 1'b0;
         done   <= 1'b0;
         busy   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         done  <= do_alu | do_nop | mul_fin;
         zWrEn <= do_alu | mul_fin;
         busy  <= do_mul | (busy & ~mul_fin);
         if (do_alu)       result <= alu_res;
         else if (mul_fin) result <= acc_nxt;
         if (do_mul) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
         end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            cnt    <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq, directed scenarios then random traffic.
// Honours ALU_MUL_EARLY_EXIT_EN for expected multiply latency.
module tb_alu_seq;

   localparam int W = 12;

   localparam logic [2:0] OP_PASS = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_DEC  = 3'd5;
   localparam logic [2:0] OP_AND  = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   typedef struct {
      int           due;
      logic [W-1:0] res;
      logic         zw;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         start;
   logic [W-1:0] result;
   logic         zWrEn;
   logic         done;
   logic         busy;

   exp_t         q[$];
   int           cyc = 0;
   int           busy_until = 0;
   int           checks = 0;
   int           npass = 0;
   logic [W-1:0] m_last = '0;
   logic         zf = 1'b0;
   logic         zf_exp = 1'b0;
   logic         zf_pend = 1'b0;
   logic         mon_en = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .op     (op),
      .start  (start),
      .result (result),
      .zWrEn  (zWrEn),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Downstream zero-flag register fed by result/zWrEn.
   always @(posedge clk) if (zWrEn) zf <= (result == '0);

   always @(negedge clk) begin : mon
      exp_t e;
      if (mon_en) begin
         if (zf_pend) begin
            checks++;
            if (zf !== zf_exp)
               $display("FAIL zflag: got %b want %b cyc %0d", zf, zf_exp, cyc);
            else npass++;
            zf_pend = 1'b0;
         end
         checks++;
         if (busy !== (cyc < busy_until))
            $display("FAIL busy: got %b want %b cyc %0d",
                     busy, (cyc < busy_until), cyc);
         else npass++;
         checks++;
         if (done) begin
            if (q.size() == 0) begin
               $display("FAIL spurious_done: result %h cyc %0d", result, cyc);
            end else begin
               e = q.pop_front();
               if (e.due != cyc || result !== e.res || zWrEn !== e.zw)
                  $display("FAIL result: got %h zw %b cyc %0d want %h zw %b cyc %0d",
                           result, zWrEn, cyc, e.res, e.zw, e.due);
               else npass++;
               if (e.zw) begin
                  zf_pend = 1'b1;
                  zf_exp  = (e.res == '0);
               end
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            $display("FAIL missing_done: got none cyc %0d want %h due %0d",
                     cyc, e.res, e.due);
         end else if (zWrEn) begin
            $display("FAIL zwren_alone: got zWrEn=1 done=0 want 0 cyc %0d", cyc);
         end else npass++;
      end
   end

   function automatic int mul_lat(input logic [W-1:0] y);
      int n;
`ifdef ALU_MUL_EARLY_EXIT_EN
      n = 1;
      for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
`else
      n = W;
`endif
      return n;
   endfunction

   function automatic logic [W-1:0] ref_val(input logic [2:0] o,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_MUL:  return x * y;
         OP_INC:  return x + W'(1);
         OP_DEC:  return x - W'(1);
         OP_AND:  return x & y;
         OP_NOP:  return m_last;
         default: return x;
      endcase
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] ex);
      exp_t e;
      @(negedge clk); #1;
      op = o; a = x; b = y; start = s;
      if (s && cyc >= busy_until) begin
         e.zw  = (o != OP_NOP);
         e.res = ex;
         if (o == OP_MUL) begin
            busy_until = cyc + 1 + mul_lat(y);
            e.due = busy_until;
         end else begin
            e.due = cyc + 1;
         end
         if (e.zw) m_last = ex;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      @(negedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < W + 8 && q.size() > 0; i++) begin
         @(negedge clk); #2;
      end
      checks++;
      if (q.size() != 0) begin
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
         q.delete();
      end else npass++;
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1;
      start = 1'b0;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (result !== '0 || done !== 1'b0 || zWrEn !== 1'b0 || busy !== 1'b0)
         $display("FAIL async_reset: got r=%h d=%b z=%b b=%b want all 0",
                  result, done, zWrEn, busy);
      else npass++;
      q.delete();
      busy_until = 0;
      m_last = '0;
      zf_pend = 1'b0;
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; op = OP_PASS; a = '0; b = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (result !== '0 || done !== 1'b0 || zWrEn !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_state: got r=%h d=%b z=%b b=%b want all 0",
                  result, done, zWrEn, busy);
      else npass++;
      rst = 1'b1;
      mon_en = 1'b1;
      issue(OP_MUL, 12'd3, 12'd5, 1'b1, 12'd15);
      #6 start = 1'b0;
      repeat (2) @(negedge clk);
      pulse_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (result !== '0) $display("FAIL reset_abort: got %h want 000", result);
      else npass++;
      issue(OP_ADD, 12'd4, 12'd0, 1'b1, 12'd4);
      drain();
      checks++;
      if (result !== 12'd4) $display("FAIL add_after_reset: got %h want 004", result);
      else npass++;
   endtask

   task automatic test_back_to_back();
      issue(OP_ADD, 12'hFFF, 12'h001, 1'b1, 12'h000);
      issue(OP_SUB, 12'h005, 12'h007, 1'b1, 12'hFFE);
      issue(OP_DEC, 12'h000, 12'h000, 1'b1, 12'hFFF);
      issue(OP_AND, 12'hF0F, 12'h0FF, 1'b1, 12'h00F);
      issue(OP_INC, 12'hFFF, 12'h000, 1'b1, 12'h000);
      issue(OP_PASS, 12'hA5C, 12'h123, 1'b1, 12'hA5C);
      drain();
   endtask

   task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ex, input int want_edges,
                          input string tag);
      int k;
      int edges;
      int nbusy;
      edges = -1;
      nbusy = 0;
      issue(OP_MUL, x, y, 1'b1, ex);
      k = cyc;
      #6 start = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         @(negedge clk);
         if (done) begin
            edges = cyc - k;
            break;
         end
         if (busy) nbusy++;
      end
      checks++;
      if (edges != want_edges || nbusy != want_edges - 1 || result !== ex)
         $display("FAIL %s: got edges %0d busy %0d r %h want %0d %0d %h",
                  tag, edges, nbusy, result, want_edges, want_edges - 1, ex);
      else npass++;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || zWrEn !== 1'b0)
         $display("FAIL %s_pulse: got d=%b z=%b want 0 0", tag, done, zWrEn);
      else npass++;
   endtask

   task automatic test_mul();
`ifdef ALU_MUL_EARLY_EXIT_EN
      run_mul(12'd3, 12'd5, 12'd15, 4, "mul_3x5");
      run_mul(12'd7, 12'd0, 12'd0, 2, "mul_7x0");
`else
      run_mul(12'd3, 12'd5, 12'd15, 13, "mul_3x5");
      run_mul(12'd7, 12'd0, 12'd0, 13, "mul_7x0");
`endif
      drain();
   endtask

   task automatic test_mul_trunc();
      issue(OP_MUL, 12'h0FF, 12'h101, 1'b1, 12'hFFF);
      issue(OP_ADD, 12'h111, 12'h222, 1'b1, 12'h000);
      issue(OP_MUL, 12'h7FF, 12'hFFF, 1'b1, 12'h000);
      issue(OP_SUB, 12'h000, 12'h001, 1'b1, 12'h000);
      drain();
      checks++;
      if (result !== 12'hFFF) $display("FAIL mul_trunc: got %h want FFF", result);
      else npass++;
   endtask

   task automatic test_nop_and_hold();
      issue(OP_NOP, 12'h123, 12'h456, 1'b1, 12'hFFF);
      drain();
      checks++;
      if (result !== 12'hFFF) $display("FAIL nop_hold: got %h want FFF", result);
      else npass++;
      issue(OP_ADD, 12'h001, 12'h002, 1'b1, 12'h003);
      issue(OP_ADD, 12'h003, 12'h004, 1'b1, 12'h007);
      issue(OP_ADD, 12'h800, 12'h800, 1'b1, 12'h000);
      issue(OP_ADD, 12'h0F0, 12'h00F, 1'b1, 12'h0FF);
      drain();
   endtask

   task automatic test_random();
      logic [2:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(63) == 0) begin
            pulse_reset();
         end else begin
            o = 3'($urandom_range(7));
            x = W'($urandom);
            y = ($urandom_range(1) == 1) ? W'($urandom) : W'($urandom_range(15));
            s = ($urandom_range(3) != 0);
            issue(o, x, y, s, ref_val(o, x, y));
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mul();
      test_mul_trunc();
      test_nop_and_hold();
      test_random();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", npass, checks);
      $finish;
   end

endmodule
